// File: rtl/csr_tohost_ctrl.sv
// Write controller for the tohost CSR: arbitrates pipeline/debug writes, queues values for the host,
// decodes pass/fail status. Optional accepted-write counter enabled by CSR_TOHOST_WCOUNT_EN.
module csr_tohost_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        mw_csr_we,
    input  logic [31:0] mw_wb_data,
    input  logic        dbg_req,
    input  logic [31:0] dbg_data,
    output logic        dbg_gnt,
    output logic        csr_we,
    output logic [31:0] csr_wdata,
    output logic        host_valid,
    output logic [31:0] host_data,
    input  logic        host_ready,
    output logic        stall_req,
    output logic        overflow,
    output logic        pass,
    output logic        fail,
    output logic [30:0] fail_code,
    output logic [15:0] wr_count
);

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_HIGH = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    state_t           state_q;
    logic             csr_we_q, stall_req_q, overflow_q;
    logic [31:0]      csr_wdata_q;
    logic [30:0]      fail_code_q;

    logic        pw, full, pop, acc, push;
    logic [31:0] acc_data;

    assign pw       = mw_csr_we & ~stall_in;
    assign full     = (count_q == CNT_FULL);
    assign pop      = host_valid & host_ready;
    assign dbg_gnt  = dbg_req & ~pw & (~full | pop);
    assign acc      = pw | dbg_gnt;
    assign acc_data = pw ? mw_wb_data : dbg_data;
    // A pipeline write into a full FIFO still reaches the CSR; it just isn't queued.
    assign push     = acc & (~full | pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= acc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csr_we_q    <= 1'b0;
            csr_wdata_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stall_req_q <= 1'b0;
            overflow_q  <= 1'b0;
            fail_code_q <= '0;
            state_q     <= ST_RUN;
        end else begin
            csr_we_q <= acc;
            if (acc) begin
                csr_wdata_q <= acc_data;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
            // Raised at DEPTH-1 so the write already in flight when the stall lands still fits.
            stall_req_q <= (count_d >= CNT_HIGH);
            if (pw && full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (acc && state_q == ST_RUN) begin
                if (acc_data == 32'h1) begin
                    state_q <= ST_PASS;
                end else if (acc_data[0]) begin
                    state_q     <= ST_FAIL;
                    fail_code_q <= acc_data[31:1];
                end
            end
        end
    end

    assign csr_we     = csr_we_q;
    assign csr_wdata  = csr_wdata_q;
    assign host_valid = (count_q != '0);
    assign host_data  = mem_q[rd_ptr_q];
    assign stall_req  = stall_req_q;
    assign overflow   = overflow_q;
    assign pass       = (state_q == ST_PASS);
    assign fail       = (state_q == ST_FAIL);
    assign fail_code  = fail_code_q;

`ifdef CSR_TOHOST_WCOUNT_EN
    logic [15:0] wr_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_q <= '0;
        end else if (acc && wr_count_q != 16'hFFFF) begin
            wr_count_q <= wr_count_q + 16'd1;
        end
    end

    assign wr_count = wr_count_q;
`else
    assign wr_count = '0;
`endif

endmodule
